// File: rtl/cdf_scratch_responder.sv
// rtl/cdf_scratch_responder.sv - CDF-stage scratch memory responder
// Serves bin reads to the CDF controller, takes write-backs in place, accepts histogram loads.
module cdf_scratch_responder #(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_first_value,
   input  logic                  read_next_value,
   input  logic                  cdf_computation_done,
   input  logic [DATA_WIDTH-1:0] cdf_wr_data,
   input  logic                  hist_wr_en,
   input  logic [ADDR_WIDTH-1:0] hist_wr_addr,
   input  logic [DATA_WIDTH-1:0] hist_wr_data,
   output logic                  scratch_mem_read_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] cur_addr,
   output logic                  busy,
   output logic                  image_done,
   output logic                  req_overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2,
      WAIT_WR = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  any_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Loads only land in IDLE and write-backs only in WAIT_WR, so one write port suffices.
   always_comb begin
      any_req   = read_first_value | read_next_value;
      mem_we    = 1'b0;
      mem_waddr = hist_wr_addr;
      mem_wdata = hist_wr_data;
      if (!reset) begin
         if (state == IDLE && hist_wr_en) begin
            mem_we = 1'b1;
         end else if (state == WAIT_WR && cdf_computation_done) begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdata = cdf_wr_data;
         end
      end
   end

   // Memory is deliberately left out of reset so histogram contents survive it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= IDLE;
         cur_addr               <= '0;
         rd_data                <= '0;
         scratch_mem_read_ready <= 1'b0;
         busy                   <= 1'b0;
         image_done             <= 1'b0;
         req_overrun            <= 1'b0;
      end else begin
         scratch_mem_read_ready <= 1'b0;
         image_done             <= 1'b0;

         if (state != IDLE && (any_req || hist_wr_en)) begin
            req_overrun <= 1'b1;
         end
         if (state != WAIT_WR && cdf_computation_done) begin
            req_overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (read_first_value) begin
                  cur_addr <= '0;
                  state    <= RD_ADDR;
                  busy     <= 1'b1;
               end else if (read_next_value) begin
                  cur_addr <= cur_addr + 1'b1;
                  state    <= RD_ADDR;
                  busy     <= 1'b1;
               end
            end
            RD_ADDR: begin
               rd_data                <= mem[cur_addr];
               scratch_mem_read_ready <= 1'b1;
               state                  <= RD_DATA;
            end
            RD_DATA: begin
               state <= WAIT_WR;
            end
            WAIT_WR: begin
               if (cdf_computation_done) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  image_done <= (cur_addr == LAST_ADDR);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdf_scratch_responder.sv
// tb/tb_cdf_scratch_responder.sv - directed bench for cdf_scratch_responder
module tb_cdf_scratch_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_first_value;
   logic        read_next_value;
   logic        cdf_computation_done;
   logic [15:0] cdf_wr_data;
   logic        hist_wr_en;
   logic [5:0]  hist_wr_addr;
   logic [15:0] hist_wr_data;
   logic        scratch_mem_read_ready;
   logic [15:0] rd_data;
   logic [5:0]  cur_addr;
   logic        busy;
   logic        image_done;
   logic        req_overrun;

   int checks = 0;
   int errors = 0;
   int done_count;

   cdf_scratch_responder #(.DEPTH(64), .ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .read_first_value       (read_first_value),
      .read_next_value        (read_next_value),
      .cdf_computation_done   (cdf_computation_done),
      .cdf_wr_data            (cdf_wr_data),
      .hist_wr_en             (hist_wr_en),
      .hist_wr_addr           (hist_wr_addr),
      .hist_wr_data           (hist_wr_data),
      .scratch_mem_read_ready (scratch_mem_read_ready),
      .rd_data                (rd_data),
      .cur_addr               (cur_addr),
      .busy                   (busy),
      .image_done             (image_done),
      .req_overrun            (req_overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(scratch_mem_read_ready), 0);
      chk({tag, "_rd_data"}, 32'(rd_data), 0);
      chk({tag, "_cur_addr"}, 32'(cur_addr), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_image_done"}, 32'(image_done), 0);
      chk({tag, "_overrun"}, 32'(req_overrun), 0);
   endtask

   task automatic load_all(input int base, input int mult);
      for (int a = 0; a < 64; a++) begin
         hist_wr_en   = 1'b1;
         hist_wr_addr = 6'(a);
         hist_wr_data = 16'(base + mult * a);
         tick();
      end
      hist_wr_en = 1'b0;
   endtask

   // Request in cycle n: busy at n+1, ready with data at n+2 only, data held in WAIT_WR.
   task automatic do_read(input bit first, input int a, input int d);
      read_first_value = first;
      read_next_value  = !first;
      tick();
      read_first_value = 1'b0;
      read_next_value  = 1'b0;
      chk("rd_busy", 32'(busy), 1);
      chk("rd_ready_early", 32'(scratch_mem_read_ready), 0);
      chk("rd_addr", 32'(cur_addr), 32'(a));
      tick();
      chk("rd_ready", 32'(scratch_mem_read_ready), 1);
      chk("rd_data", 32'(rd_data), 32'(d));
      tick();
      chk("rd_ready_pulse", 32'(scratch_mem_read_ready), 0);
      chk("rd_data_hold", 32'(rd_data), 32'(d));
   endtask

   task automatic write_back(input int d, input bit done_exp);
      cdf_computation_done = 1'b1;
      cdf_wr_data          = 16'(d);
      tick();
      cdf_computation_done = 1'b0;
      chk("wb_busy", 32'(busy), 0);
      chk("wb_image_done", 32'(image_done), 32'(done_exp));
      if (image_done) done_count++;
      tick();
      chk("wb_done_pulse", 32'(image_done), 0);
   endtask

   initial begin
      reset = 1'b1;
      read_first_value = 1'b0;
      read_next_value = 1'b0;
      cdf_computation_done = 1'b0;
      cdf_wr_data = '0;
      hist_wr_en = 1'b0;
      hist_wr_addr = '0;
      hist_wr_data = '0;
      done_count = 0;
      tick();
      tick();
      reset = 1'b0;
      chk_all_zero("reset");

      load_all(0, 2);
      chk("load_busy", 32'(busy), 0);
      chk("load_overrun", 32'(req_overrun), 0);

      do_read(1'b1, 0, 0);
      write_back(100, 1'b0);
      for (int a = 1; a < 64; a++) begin
         do_read(1'b0, a, 2 * a);
         write_back(100 + a, a == 63);
      end
      chk("image_done_count", 32'(done_count), 1);
      chk("full_overrun", 32'(req_overrun), 0);

      do_read(1'b0, 0, 100);
      write_back(100, 1'b0);

      do_read(1'b1, 0, 100);
      write_back(100, 1'b0);
      for (int a = 1; a <= 5; a++) begin
         do_read(1'b0, a, 100 + a);
         write_back(100 + a, 1'b0);
      end
      chk("reread_bin5", 32'(rd_data), 105);

      do_read(1'b0, 6, 106);
      write_back(106, 1'b0);
      do_read(1'b0, 7, 107);
      write_back(107, 1'b0);
      read_first_value = 1'b1;
      read_next_value  = 1'b1;
      tick();
      read_first_value = 1'b0;
      read_next_value  = 1'b0;
      chk("both_addr", 32'(cur_addr), 0);
      chk("both_overrun", 32'(req_overrun), 0);
      tick();
      chk("both_rd_data", 32'(rd_data), 100);
      tick();
      write_back(100, 1'b0);

      // Request during RD_DATA and load during WAIT_WR are dropped.
      read_next_value = 1'b1;
      tick();
      read_next_value = 1'b0;
      tick();
      chk("ovr_ready", 32'(scratch_mem_read_ready), 1);
      chk("ovr_rd_data", 32'(rd_data), 101);
      read_next_value = 1'b1;
      tick();
      read_next_value = 1'b0;
      chk("ovr_flag", 32'(req_overrun), 1);
      chk("ovr_addr", 32'(cur_addr), 1);
      hist_wr_en   = 1'b1;
      hist_wr_addr = 6'd9;
      hist_wr_data = 16'hdead;
      tick();
      hist_wr_en = 1'b0;
      chk("ovr_busy", 32'(busy), 1);
      write_back(101, 1'b0);
      for (int a = 2; a <= 9; a++) begin
         do_read(1'b0, a, 100 + a);
         write_back(100 + a, 1'b0);
      end
      chk("ovr_sticky", 32'(req_overrun), 1);

      load_all(0, 2);
      read_first_value = 1'b1;
      tick();
      read_first_value = 1'b0;
      tick();
      chk("rst_pre_ready", 32'(scratch_mem_read_ready), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all_zero("rst_rd_data_state");
      tick();
      chk("rst_no_ready", 32'(scratch_mem_read_ready), 0);
      chk("rst_no_busy", 32'(busy), 0);

      // Write-back strobe coinciding with reset is not performed.
      read_first_value = 1'b1;
      tick();
      read_first_value = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      cdf_computation_done = 1'b1;
      cdf_wr_data = 16'hffff;
      tick();
      reset = 1'b0;
      cdf_computation_done = 1'b0;
      chk_all_zero("rst_wait_wr");
      tick();
      chk("rst_no_done", 32'(image_done), 0);

      do_read(1'b1, 0, 0);
      write_back(0, 1'b0);
      for (int a = 1; a <= 3; a++) begin
         do_read(1'b0, a, 2 * a);
         write_back(2 * a, 1'b0);
      end
      chk("rst_retain_bin3", 32'(rd_data), 6);

      // Load and request in the same IDLE cycle: read sees the new data.
      hist_wr_en   = 1'b1;
      hist_wr_addr = 6'd0;
      hist_wr_data = 16'h1234;
      read_first_value = 1'b1;
      tick();
      hist_wr_en = 1'b0;
      read_first_value = 1'b0;
      tick();
      chk("load_req_ready", 32'(scratch_mem_read_ready), 1);
      chk("load_req_data", 32'(rd_data), 32'h1234);
      chk("final_overrun", 32'(req_overrun), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
